io_port: RTL and testbench
==========================

IO_PORT -- requirements
Module: io_port

Interface
REQ-001 Parameter: TX_DEPTH, default 4, TX FIFO depth in entries; power of two, at least 2.
REQ-002 Port: clk  input  1  single system clock; all state updates on its rising edge.
REQ-003 Port: reset  input  1  synchronous, active-high reset, sampled on rising clk.
REQ-004 Port: mem_io  input  1  CPU I/O-space select.
REQ-005 Port: mem_clk  input  1  CPU memory strobe phase, level-sampled on clk.
REQ-006 Port: c_ri  input  1  CPU write strobe (CPU drives bus).
REQ-007 Port: c_ro  input  1  CPU read strobe (io_port drives bus).
REQ-008 Port: addr_bus  input  8  I/O register address.
REQ-009 Port: bus  inout  8  shared data bus.
REQ-010 Port: tx_data  output  8  head of TX FIFO.
REQ-011 Port: tx_valid  output  1  TX FIFO non-empty.
REQ-012 Port: tx_ready  input  1  consumer accepts tx_data.
REQ-013 Port: rx_data  input  8  external input byte.
REQ-014 Port: rx_valid  input  1  rx_data valid.
REQ-015 Port: rx_ready  output  1  RX holding register empty.

Function
REQ-016 Access qualifier: acc = mem_io & mem_clk & (c_ri | c_ro); registered copy acc_q.
REQ-017 Leading edge (acc & !acc_q): the write side effect executes exactly once per access, regardless of how many cycles mem_clk stays high.
REQ-018 Trailing edge (!acc & acc_q): the read side effect executes exactly once, using the address and strobe latched at the leading edge.
REQ-019 Register map: $00 OUT (write pushes TX FIFO; reads return $00), $01 IN (read returns RX holding, pops it), $02 STATUS (read; any write clears sticky bits).
REQ-020 STATUS bits: [0] tx_full, [1] tx_empty, [2] rx_held, [3] tx_overflow (sticky), [7:4] zero.
REQ-021 Bus drive: bus = read data while mem_io & mem_clk & c_ro & addr_bus in $00..$02; otherwise high-Z; combinational from current state.
REQ-022 Unmapped addresses ($03..$FF): never drive bus; writes have no effect.
REQ-023 IN read with rx_held=0: returns $00; no state change.
REQ-024 Write to $00 when not full: data enters FIFO tail; count+1.
REQ-025 Write to $00 when full and no same-cycle pop: data dropped; tx_overflow set.
REQ-026 Write to $00 when full with same-cycle pop: write accepted; count unchanged; no overflow.
REQ-027 Pop: tx_valid & tx_ready on a rising edge advances the head; tx_data shows the next entry the following cycle.
REQ-028 Pointers wrap modulo TX_DEPTH; the count is log2(TX_DEPTH)+1 bits wide and never exceeds TX_DEPTH.
REQ-029 rx_ready = !rx_held; rx_valid & rx_ready on a rising edge latches rx_data and sets rx_held.
REQ-030 IN pop and a new RX capture in the same cycle: the capture wins; rx_held stays 1 with the new byte.
REQ-031 A write to $02 in the same cycle as an overflow event: the clear wins.

Reset
REQ-032 reset=1: FIFO empty (pointers and count = 0), tx_valid=0, rx_held=0, rx_ready=1, tx_overflow=0, acc_q=0, bus high-Z.
REQ-033 Reset during an access: the access is abandoned; no trailing-edge pop follows; the access counts as new only after acc drops and re-rises.
REQ-034 tx_data is don't-care while tx_valid=0.

Verification
REQ-035 Reset, then write $11,$22,$33,$44 to $00 with tx_ready=0 -> STATUS=$01 after the 4th write; a 5th write of $55 -> STATUS=$09, FIFO still holds $11..$44.
REQ-036 tx_ready=1 after REQ-035 -> tx_data $11,$22,$33,$44 on consecutive cycles, then tx_valid=0, STATUS=$0A; write $02 -> STATUS=$02.
REQ-037 rx_valid=1, rx_data=$A5 -> rx_ready=0 next cycle; read $01 -> bus=$A5 during the access, then rx_ready=1, STATUS bit2=0; second read -> $00.
REQ-038 mem_clk held high 5 cycles on a single write of $7E to $00 -> exactly one FIFO entry ($7E), count=1.
REQ-039 FIFO full, tx_ready=1, write $66 in the pop cycle -> no overflow, count stays 4, $66 emerges last.
REQ-040 Read $05 -> bus high-Z; reset asserted mid IN-read with rx_held=1 -> rx_held=0, no spurious pop afterwards.

Source files
------------

// File: rtl/io_port.sv
// io_port: CPU I/O register block with a TX FIFO, an RX holding register and sticky status.
module io_port #(
  parameter int TX_DEPTH = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       mem_io,
  input  logic       mem_clk,
  input  logic       c_ri,
  input  logic       c_ro,
  input  logic [7:0] addr_bus,
  inout  wire  [7:0] bus,
  output logic [7:0] tx_data,
  output logic       tx_valid,
  input  logic       tx_ready,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic       rx_ready
);
  localparam int AW = $clog2(TX_DEPTH);
  logic [7:0]  r_mem [TX_DEPTH];
  logic [AW-1:0] r_wp, r_rp;
  logic [AW:0] r_cnt;
  logic        r_acc_q, r_blk, r_ro, r_ovf, r_held;
  logic [7:0]  r_addr, r_rx;
  logic        w_acc, w_lead, w_trail, w_full, w_pop, w_wr, w_push, w_ov, w_clr, w_rpop, w_cap, w_drv;
  logic [7:0]  w_stat, w_rd;
  assign w_acc   = mem_io & mem_clk & (c_ri | c_ro);
  assign w_lead  = w_acc & ~r_acc_q & ~r_blk;
  assign w_trail = ~w_acc & r_acc_q;
  assign w_full  = r_cnt == (AW+1)'(TX_DEPTH);
  assign w_pop   = tx_valid & tx_ready;
  assign w_wr    = w_lead & c_ri & (addr_bus == 8'h00);
  assign w_push  = w_wr & (~w_full | w_pop);
  assign w_ov    = w_wr & w_full & ~w_pop;
  assign w_clr   = w_lead & c_ri & (addr_bus == 8'h02);
  assign w_rpop  = w_trail & r_ro & (r_addr == 8'h01);
  assign w_cap   = rx_valid & rx_ready;
  assign tx_valid = r_cnt != '0;
  assign tx_data  = r_mem[r_rp];
  assign rx_ready = ~r_held;
  assign w_stat = {4'h0, r_ovf, r_held, ~tx_valid, w_full};
  assign w_rd   = addr_bus == 8'h01 ? (r_held ? r_rx : 8'h00) : addr_bus == 8'h02 ? w_stat : 8'h00;
  assign w_drv  = ~reset & mem_io & mem_clk & c_ro & (addr_bus <= 8'h02);
  assign bus    = w_drv ? w_rd : 8'hzz;
  // r_blk keeps an access that straddled reset from being seen as new until acc drops
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wp    <= '0;
      r_rp    <= '0;
      r_cnt   <= '0;
      r_acc_q <= 1'b0;
      r_blk   <= w_acc;
      r_ovf   <= 1'b0;
      r_held  <= 1'b0;
    end else begin
      r_acc_q <= w_acc & ~r_blk;
      r_blk   <= r_blk & w_acc;
      if (w_lead) begin
        r_addr <= addr_bus;
        r_ro   <= c_ro;
      end
      if (w_push) begin
        r_mem[r_wp] <= bus;
        r_wp <= r_wp + 1'b1;
      end
      if (w_pop) r_rp <= r_rp + 1'b1;
      r_cnt <= r_cnt + (AW+1)'(w_push) - (AW+1)'(w_pop);
      r_ovf <= w_clr ? 1'b0 : (w_ov ? 1'b1 : r_ovf);
      if (w_cap) begin
        r_held <= 1'b1;
        r_rx   <= rx_data;
      end else if (w_rpop) r_held <= 1'b0;
    end
  end
endmodule

// File: tb/tb_io_port.sv
// tb_io_port: directed and random CPU accesses checked against a queue-based model of io_port.
module tb_io_port;
  localparam int D = 4;
  logic clk = 0, reset, mem_io, mem_clk, c_ri, c_ro, tx_valid, tx_ready, rx_valid, rx_ready;
  logic [7:0] addr_bus, tx_data, rx_data, cpu_d;
  logic cpu_oe;
  wire  [7:0] bus;
  int n_chk = 0, n_err = 0;
  logic [7:0] q[$];
  bit m_held, m_ovf, m_lead, m_trail, t_ro;
  logic [7:0] m_rx, t_addr, last_bus, last_tx, seen;
  io_port #(.TX_DEPTH(D)) dut (.clk(clk), .reset(reset), .mem_io(mem_io), .mem_clk(mem_clk),
    .c_ri(c_ri), .c_ro(c_ro), .addr_bus(addr_bus), .bus(bus), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid), .rx_ready(rx_ready));
  assign bus = cpu_oe ? cpu_d : 8'hzz;
  for (genvar i = 0; i < 8; i++) begin : g_pu
    pullup (bus[i]);
  end
  always #5 clk = ~clk;
  task automatic chk(input string tag, input logic [7:0] o, input logic [7:0] e);
    n_chk++;
    assert (o === e) else begin
      n_err++;
      $error("FAIL %s: got %h expected %h", tag, o, e);
    end
  endtask
  function automatic logic [7:0] rd_model(input logic [7:0] a);
    if (a == 8'h01) return m_held ? m_rx : 8'h00;
    if (a == 8'h02) return {4'h0, m_ovf, m_held, q.size() == 0, q.size() == D};
    return 8'h00;
  endfunction
  task automatic tick();
    bit pop, push;
    #4;
    last_bus = bus;
    last_tx = tx_data;
    chk("tx_valid", tx_valid, q.size() > 0);
    if (q.size() > 0) chk("tx_data", tx_data, q[0]);
    chk("rx_ready", rx_ready, !m_held);
    chk("bus", bus, cpu_oe ? cpu_d : (!reset && mem_io && mem_clk && c_ro && addr_bus <= 2) ? rd_model(addr_bus) : 8'hFF);
    if (reset) begin
      q.delete(); m_held = 0; m_ovf = 0;
    end else begin
      pop = q.size() > 0 && tx_ready;
      push = 0;
      if (m_lead && c_ri && addr_bus == 8'h00) begin
        if (q.size() < D || pop) push = 1; else m_ovf = 1;
      end
      if (m_lead && c_ri && addr_bus == 8'h02) m_ovf = 0;
      if (pop) void'(q.pop_front());
      if (push) q.push_back(cpu_d);
      if (rx_valid && !m_held) begin
        m_held = 1; m_rx = rx_data;
      end else if (m_trail && t_ro && t_addr == 8'h01) m_held = 0;
    end
    m_lead = 0; m_trail = 0;
    @(posedge clk); #1;
  endtask
  task automatic access(input bit wr, input logic [7:0] a, input logic [7:0] d, input int hold, output logic [7:0] s);
    mem_io = 1; mem_clk = 1; c_ri = wr; c_ro = !wr; addr_bus = a; cpu_d = d; cpu_oe = wr;
    m_lead = 1; t_ro = !wr; t_addr = a;
    tick();
    s = last_bus;
    for (int k = 1; k < hold; k++) tick();
    mem_io = 0; mem_clk = 0; c_ri = 0; c_ro = 0; cpu_oe = 0; m_trail = 1;
    tick();
  endtask
  initial begin
    logic [7:0] v [4];
    reset = 1; mem_io = 0; mem_clk = 0; c_ri = 0; c_ro = 0; addr_bus = 0; cpu_d = 0; cpu_oe = 0;
    tx_ready = 0; rx_valid = 0; rx_data = 0; m_lead = 0; m_trail = 0; t_ro = 0; t_addr = 0;
    repeat (2) @(posedge clk);
    #1 reset = 0;
    chk("rst_tx_valid", tx_valid, 0);
    chk("rst_rx_ready", rx_ready, 1);
    access(0, 8'h02, 0, 1, seen); chk("rst_status", seen, 8'h02);
    foreach (v[k]) begin v[k] = 8'(8'h11 * (k + 1)); access(1, 8'h00, v[k], 1, seen); end
    access(0, 8'h02, 0, 1, seen); chk("full_status", seen, 8'h01);
    access(1, 8'h00, 8'h55, 1, seen);
    access(0, 8'h02, 0, 1, seen); chk("ovf_status", seen, 8'h09);
    tx_ready = 1;
    foreach (v[k]) begin tick(); chk("drain", last_tx, v[k]); end
    chk("drained", tx_valid, 0);
    access(0, 8'h02, 0, 1, seen); chk("empty_ovf_status", seen, 8'h0A);
    access(1, 8'h02, 0, 1, seen);
    access(0, 8'h02, 0, 1, seen); chk("cleared_status", seen, 8'h02);
    rx_valid = 1; rx_data = 8'hA5; tick(); rx_valid = 0;
    chk("rx_ready_lo", rx_ready, 0);
    access(0, 8'h01, 0, 2, seen); chk("in_read", seen, 8'hA5);
    chk("rx_ready_hi", rx_ready, 1);
    access(0, 8'h02, 0, 1, seen); chk("rx_status", seen, 8'h02);
    access(0, 8'h01, 0, 1, seen); chk("in_empty", seen, 8'h00);
    tx_ready = 0;
    access(1, 8'h00, 8'h7E, 5, seen);
    chk("hold_valid", tx_valid, 1); chk("hold_data", tx_data, 8'h7E);
    tx_ready = 1; tick(); chk("hold_single", tx_valid, 0);
    tx_ready = 0;
    foreach (v[k]) begin v[k] = 8'(8'hA1 + k); access(1, 8'h00, v[k], 1, seen); end
    tx_ready = 1; access(1, 8'h00, 8'h66, 1, seen); tx_ready = 0;
    access(0, 8'h02, 0, 1, seen); chk("pop_push_status", seen, 8'h00);
    v[0] = 8'hA3; v[1] = 8'hA4; v[2] = 8'h66;
    tx_ready = 1;
    for (int k = 0; k < 3; k++) begin tick(); chk("pp_drain", last_tx, v[k]); end
    chk("pp_empty", tx_valid, 0);
    tx_ready = 0;
    access(0, 8'h05, 0, 1, seen); chk("unmapped_z", seen, 8'hFF);
    rx_valid = 1; rx_data = 8'hB7; tick(); rx_valid = 0;
    mem_io = 1; mem_clk = 1; c_ro = 1; addr_bus = 8'h01; m_lead = 1; t_ro = 1; t_addr = 8'h01;
    tick(); chk("pre_rst_read", last_bus, 8'hB7);
    reset = 1; tick(); reset = 0;
    chk("rst_rx_held", rx_ready, 1);
    rx_valid = 1; rx_data = 8'hC4; tick(); rx_valid = 0;
    tick();
    mem_io = 0; mem_clk = 0; c_ro = 0; tick();
    chk("no_spurious_pop", rx_ready, 0);
    access(0, 8'h01, 0, 1, seen); chk("post_rst_in", seen, 8'hC4);
    for (int n = 0; n < 300; n++) begin
      int op;
      op = int'($urandom_range(0, 5));
      tx_ready = 1'($urandom); rx_valid = 1'($urandom); rx_data = 8'($urandom);
      case (op)
        0, 1: access(1, 8'h00, 8'($urandom), int'($urandom_range(1, 3)), seen);
        2: access(0, 8'h01, 0, int'($urandom_range(1, 3)), seen);
        3: access(0, 8'h02, 0, int'($urandom_range(1, 3)), seen);
        4: access(1, 8'h02, 8'($urandom), 1, seen);
        default: access(1'($urandom), 8'($urandom_range(3, 255)), 8'($urandom), 1, seen);
      endcase
      repeat ($urandom_range(0, 2)) tick();
    end
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
